// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES-128 constants, S-box table, rcon and FSM state type shared by the key schedule blocks
package aes_pkg;

    localparam int KEY_W         = 128;
    localparam int WORD_W        = 32;
    localparam int AES_NB_ROUNDS = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_XOR3,
        ST_XOR2,
        ST_XOR1,
        ST_SUB,
        ST_XOR0,
        ST_DONE
    } state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] rcon(input logic [3:0] round);
        case (round)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/sub_word.sv
// rtl/sub_word.sv - four parallel S-box lookups with a registered 32-bit result, one cycle latency
module sub_word
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic [WORD_W-1:0] word_in,
    output logic [WORD_W-1:0] word_out
);

    always_ff @(posedge clk) begin
        word_out <= {SBOX[word_in[31:24]], SBOX[word_in[23:16]],
                     SBOX[word_in[15:8]],  SBOX[word_in[7:0]]};
    end

endmodule

// File: rtl/inv_key_expansion.sv
// rtl/inv_key_expansion.sv - inverse AES-128 key schedule walker; INV_KEY_STEP_OUT_EN adds per-round key strobes
module inv_key_expansion
    import aes_pkg::*;
#(
    parameter int NB_ROUNDS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    input  logic [3:0]       src_round,
    input  logic [3:0]       dst_round,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic [3:0]       key_round
);

    localparam logic [3:0] MAX_ROUND = 4'(NB_ROUNDS);

    state_t            state;
    state_t            state_next;
    logic [WORD_W-1:0] w0, w1, w2, w3;
    logic [WORD_W-1:0] rot_w3;
    logic [WORD_W-1:0] sub_out;
    logic [WORD_W-1:0] w0_new;
    logic [3:0]        rnd;
    logic [3:0]        dst;
    logic [3:0]        rnd_dec;
    logic              start_ok;

    assign start_ok = (src_round != 4'd0) && (src_round <= MAX_ROUND) && (dst_round < src_round);
    assign rnd_dec  = rnd - 4'd1;
    assign rot_w3   = rot_word(w3);
    // rcon is indexed by the round being undone, before the counter decrements
    assign w0_new   = w0 ^ sub_out ^ {rcon(rnd), 24'h0};
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);

    sub_word u_sub_word (
        .clk      (clk),
        .word_in  (rot_w3),
        .word_out (sub_out)
    );

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (start && start_ok) state_next = ST_XOR3;
            ST_XOR3: state_next = ST_XOR2;
            ST_XOR2: state_next = ST_XOR1;
            ST_XOR1: state_next = ST_SUB;
            ST_SUB:  state_next = ST_XOR0;
            ST_XOR0: state_next = (rnd_dec == dst) ? ST_DONE : ST_XOR3;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            w0      <= '0;
            w1      <= '0;
            w2      <= '0;
            w3      <= '0;
            rnd     <= '0;
            dst     <= '0;
            err     <= 1'b0;
            key_out <= '0;
`ifdef INV_KEY_STEP_OUT_EN
            key_valid <= 1'b0;
            key_round <= '0;
`endif
        end else begin
            state <= state_next;
            err   <= 1'b0;
`ifdef INV_KEY_STEP_OUT_EN
            key_valid <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (start_ok) begin
                            {w0, w1, w2, w3} <= key_in;
                            rnd              <= src_round;
                            dst              <= dst_round;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_XOR3: w3 <= w3 ^ w2;
                ST_XOR2: w2 <= w2 ^ w1;
                ST_XOR1: w1 <= w1 ^ w0;
                ST_XOR0: begin
                    w0  <= w0_new;
                    rnd <= rnd_dec;
                    // key_out is loaded on the way into DONE so it is valid in the done cycle
`ifdef INV_KEY_STEP_OUT_EN
                    key_out   <= {w0_new, w1, w2, w3};
                    key_round <= rnd_dec;
                    key_valid <= 1'b1;
`else
                    if (rnd_dec == dst) key_out <= {w0_new, w1, w2, w3};
`endif
                end
                default: ;
            endcase
        end
    end

`ifndef INV_KEY_STEP_OUT_EN
    assign key_valid = 1'b0;
    assign key_round = 4'd0;
`endif

endmodule
